// File: rtl/ysyx_22040759_axi_mem_slave.sv
// AXI4 responder backed by an on-chip 64-bit word array: one transaction at a time,
// round-robin read/write arbitration, FIXED/INCR/WRAP bursts, byte-strobed writes.
module ysyx_22040759_axi_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    USER_WIDTH = 1,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic [ID_WIDTH-1:0]     aw_id,
  input  logic [7:0]              aw_len,
  input  logic [2:0]              aw_size,
  input  logic [1:0]              aw_burst,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic [1:0]              b_resp,
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [USER_WIDTH-1:0]   b_user,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic [ID_WIDTH-1:0]     ar_id,
  input  logic [7:0]              ar_len,
  input  logic [2:0]              ar_size,
  input  logic [1:0]              ar_burst,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_last,
  output logic [ID_WIDTH-1:0]     r_id,
  output logic [USER_WIDTH-1:0]   r_user,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {IDLE, AR_ACK, RD, AW_ACK, WR, WRESP} state_t;

  localparam int         IDX_W       = $clog2(MEM_WORDS);
  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                  state, state_n;
  logic                    last_grant_wr;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [7:0]              cur_len;
  logic [2:0]              cur_size;
  logic [1:0]              cur_burst;
  logic [8:0]              beat_cnt;
  logic                    wr_err;
  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0]   nxt_addr, rd_addr;
  logic [IDX_W-1:0]        rd_idx, wr_idx;
  logic                    rd_ok, rd_bad, wr_ok, wr_over, mem_we;

  function automatic logic cfg_bad(input logic [2:0] size, input logic [7:0] len,
                                   input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'd3) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  // Illegal sizes step by a full word; illegal WRAP lengths and burst 11 behave as INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [2:0]            esz;
    logic [ADDR_WIDTH-1:0] inc, mask;
    esz  = (size > 3'd3) ? 3'd3 : size;
    inc  = a + ({{(ADDR_WIDTH-1){1'b0}}, 1'b1} << esz);
    mask = (({{(ADDR_WIDTH-8){1'b0}}, len} + 1'b1) << esz) - 1'b1;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && !cfg_bad(size, len, burst)) return (a & ~mask) | (inc & mask);
    return inc;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> (IDX_W + 3)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  always_comb begin
    nxt_addr = next_addr(cur_addr, cur_len, cur_size, cur_burst);
    rd_addr  = (state == AR_ACK) ? ar_addr : nxt_addr;
    rd_bad   = (state == AR_ACK) ? cfg_bad(ar_size, ar_len, ar_burst)
                                 : cfg_bad(cur_size, cur_len, cur_burst);
    rd_ok    = in_range(rd_addr);
    rd_idx   = word_idx(rd_addr);
    wr_ok    = in_range(cur_addr);
    wr_idx   = word_idx(cur_addr);
    wr_over  = beat_cnt > {1'b0, cur_len};
    mem_we   = (state == WR) && w_valid && wr_ok && !wr_over;
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // this side raises its ready/valid purely from the FSM state and never waits on the peer.
  always_comb begin
    state_n  = state;
    ar_ready = 1'b0;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    r_valid  = 1'b0;
    b_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (ar_valid && (!aw_valid || last_grant_wr)) state_n = AR_ACK;
        else if (aw_valid)                              state_n = AW_ACK;
      end
      AR_ACK: begin
        ar_ready = 1'b1;
        state_n  = RD;
      end
      RD: begin
        r_valid = 1'b1;
        if (r_ready && r_last) state_n = IDLE;
      end
      AW_ACK: begin
        aw_ready = 1'b1;
        state_n  = WR;
      end
      WR: begin
        w_ready = 1'b1;
        if (w_valid && w_last) state_n = WRESP;
      end
      WRESP: begin
        b_valid = 1'b1;
        if (b_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // r_data is loaded one beat ahead: from ar_addr in AR_ACK, from the next beat address on each r handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_wr <= 1'b1;
      cur_addr      <= '0;
      cur_len       <= '0;
      cur_size      <= '0;
      cur_burst     <= '0;
      beat_cnt      <= '0;
      wr_err        <= 1'b0;
      r_data        <= '0;
      r_resp        <= RESP_OKAY;
      r_last        <= 1'b0;
      r_id          <= '0;
      b_id          <= '0;
      b_resp        <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (state_n == AR_ACK)      last_grant_wr <= 1'b0;
          else if (state_n == AW_ACK) last_grant_wr <= 1'b1;
        end
        AR_ACK: begin
          cur_addr  <= ar_addr;
          cur_len   <= ar_len;
          cur_size  <= ar_size;
          cur_burst <= ar_burst;
          beat_cnt  <= '0;
          r_id      <= ar_id;
          r_data    <= rd_ok ? mem[rd_idx] : '0;
          r_resp    <= (rd_ok && !rd_bad) ? RESP_OKAY : RESP_SLVERR;
          r_last    <= (ar_len == 8'd0);
        end
        RD: begin
          if (r_ready) begin
            cur_addr <= nxt_addr;
            beat_cnt <= beat_cnt + 9'd1;
            r_data   <= rd_ok ? mem[rd_idx] : '0;
            r_resp   <= (rd_ok && !rd_bad) ? RESP_OKAY : RESP_SLVERR;
            r_last   <= (beat_cnt[7:0] + 8'd1 == cur_len);
          end
        end
        AW_ACK: begin
          cur_addr  <= aw_addr;
          cur_len   <= aw_len;
          cur_size  <= aw_size;
          cur_burst <= aw_burst;
          beat_cnt  <= '0;
          b_id      <= aw_id;
          wr_err    <= cfg_bad(aw_size, aw_len, aw_burst);
        end
        WR: begin
          if (w_valid) begin
            cur_addr <= nxt_addr;
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 9'd1;
            if (wr_over || !wr_ok) wr_err <= 1'b1;
            if (w_last)
              b_resp <= (wr_err || wr_over || !wr_ok || beat_cnt != {1'b0, cur_len})
                        ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: ;
      endcase
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (mem_we)
      for (int b = 0; b < STRB_W; b++)
        if (w_strb[b]) mem[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
  end

  assign b_user    = '0;
  assign r_user    = '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_22040759_axi_mem_slave.sv
// Directed bench for ysyx_22040759_axi_mem_slave: reads, writes, strobes, WRAP,
// arbitration order, error responses and reset in the middle of a burst.
module tb_ysyx_22040759_axi_mem_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        aw_valid = 0, aw_ready;
  logic [31:0] aw_addr = 0;
  logic [3:0]  aw_id = 0;
  logic [7:0]  aw_len = 0;
  logic [2:0]  aw_size = 0;
  logic [1:0]  aw_burst = 0;
  logic        w_valid = 0, w_ready;
  logic [63:0] w_data = 0;
  logic [7:0]  w_strb = 0;
  logic        w_last = 0;
  logic        b_valid, b_ready = 0;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic [0:0]  b_user;
  logic        ar_valid = 0, ar_ready;
  logic [31:0] ar_addr = 0;
  logic [3:0]  ar_id = 0;
  logic [7:0]  ar_len = 0;
  logic [2:0]  ar_size = 0;
  logic [1:0]  ar_burst = 0;
  logic        r_valid, r_ready = 0;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;
  logic [0:0]  r_user;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] wbuf [16];
  logic [7:0]  sbuf [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;
  logic [1:0]  wresp;
  logic [3:0]  wid;

  ysyx_22040759_axi_mem_slave dut (
    .clock(clock), .reset(reset),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id), .b_user(b_user),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id), .r_user(r_user), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver tasks; all inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                           output logic [1:0] resp, output logic [3:0] bid);
    int t;
    aw_addr = addr; aw_id = id; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1;
    t = 0;
    while (!aw_ready && t < 20) begin tick(); t++; end
    check("aw_handshake", aw_ready, 1);
    tick();
    aw_valid = 0;
    for (int i = 0; i < nbeats; i++) begin
      w_data = wbuf[i]; w_strb = sbuf[i]; w_last = (i == nbeats - 1); w_valid = 1;
      t = 0;
      while (!w_ready && t < 20) begin tick(); t++; end
      tick();
    end
    w_valid = 0; w_last = 0; b_ready = 1;
    t = 0;
    while (!b_valid && t < 20) begin tick(); t++; end
    check("b_handshake", b_valid, 1);
    resp = b_resp;
    bid  = b_id;
    tick();
    b_ready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input bit stall);
    int          t, beat;
    bit          held;
    logic [63:0] hold_data;
    logic        hold_last;
    ar_addr = addr; ar_id = id; ar_len = len; ar_size = 3; ar_burst = burst; ar_valid = 1;
    t = 0;
    while (!ar_ready && t < 20) begin tick(); t++; end
    check("ar_handshake", ar_ready, 1);
    tick();
    ar_valid = 0;
    beat = 0; t = 0; held = 0; hold_data = '0; hold_last = 0;
    while (beat <= int'(len) && t < 300) begin
      r_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (held && r_valid) begin
        check("stall_data_hold", r_data, hold_data);
        check("stall_last_hold", r_last, hold_last);
      end
      if (r_valid && r_ready) begin
        rd_data[beat] = r_data; rd_resp[beat] = r_resp; rd_last[beat] = r_last; rd_id = r_id;
        beat++;
        held = 0;
      end else if (r_valid) begin
        held = 1; hold_data = r_data; hold_last = r_last;
      end
      tick();
      t++;
    end
    r_ready = 0;
    check("read_beats_done", beat, int'(len) + 1);
  endtask

  // Scoreboard of expected words for multi-beat reads
  logic [63:0] exp_q[$];

  task automatic check_read_q(input string tag);
    for (int i = 0; i < 16 && exp_q.size() > 0; i++) begin
      check(tag, rd_data[i], exp_q.pop_front());
    end
  endtask

  initial begin
    // Reset values
    tick(); tick();
    check("rst_state", dbg_state, 0);
    check("rst_readies", {ar_ready, aw_ready, w_ready}, 0);
    check("rst_valids", {r_valid, b_valid, r_last}, 0);
    check("rst_resp_id", {b_resp, r_resp, b_id, r_id}, 0);
    check("rst_r_data", r_data, 0);
    reset = 0;

    // Single write to word 2, then single read with latency checks
    wbuf[0] = 64'hDEAD_BEEF_0123_4567; sbuf[0] = 8'hFF;
    axi_write(32'h8000_0010, 4'd3, 8'd0, 3'd3, 2'b01, 1, wresp, wid);
    check("w1_bresp", wresp, 2'b00);
    check("w1_bid", wid, 4'd3);

    ar_addr = 32'h8000_0010; ar_id = 4'd5; ar_len = 0; ar_size = 3; ar_burst = 2'b01;
    ar_valid = 1;
    tick();
    check("r1_ar_ready_n1", ar_ready, 1);
    check("r1_r_valid_n1", r_valid, 0);
    tick();
    ar_valid = 0;
    r_ready  = 1;
    check("r1_r_valid_n2", r_valid, 1);
    check("r1_data", r_data, 64'hDEAD_BEEF_0123_4567);
    check("r1_last", r_last, 1);
    check("r1_id", r_id, 4'd5);
    check("r1_resp", r_resp, 2'b00);
    tick();
    r_ready = 0;
    check("r1_done", r_valid, 0);

    // INCR write of 4 beats, read back with random r_ready stalls
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    for (int i = 0; i < 4; i++) sbuf[i] = 8'hFF;
    axi_write(32'h8000_0100, 4'd7, 8'd3, 3'd3, 2'b01, 4, wresp, wid);
    check("w4_bresp", wresp, 2'b00);
    axi_read(32'h8000_0100, 4'd9, 8'd3, 2'b01, 1);
    exp_q = '{64'h11, 64'h22, 64'h33, 64'h44};
    check_read_q("r4_data");
    check("r4_last_b0", rd_last[0], 0);
    check("r4_last_b2", rd_last[2], 0);
    check("r4_last_b3", rd_last[3], 1);
    check("r4_resp", rd_resp[3], 2'b00);
    check("r4_id", rd_id, 4'd9);

    // Fill words 0..3, then WRAP write at word 3 with only the low four lanes enabled
    wbuf[0] = 64'hCAFE_0000_8888_8880; wbuf[1] = 64'hCAFE_0001_8888_8881;
    wbuf[2] = 64'hCAFE_0002_8888_8882; wbuf[3] = 64'hCAFE_0003_8888_8883;
    for (int i = 0; i < 4; i++) sbuf[i] = 8'hFF;
    axi_write(32'h8000_0000, 4'd1, 8'd3, 3'd3, 2'b01, 4, wresp, wid);
    check("fill_bresp", wresp, 2'b00);
    wbuf[0] = 64'hFFFF_FFFF_0000_00B0; wbuf[1] = 64'hFFFF_FFFF_0000_00B1;
    wbuf[2] = 64'hFFFF_FFFF_0000_00B2; wbuf[3] = 64'hFFFF_FFFF_0000_00B3;
    for (int i = 0; i < 4; i++) sbuf[i] = 8'h0F;
    axi_write(32'h8000_0018, 4'd2, 8'd3, 3'd3, 2'b10, 4, wresp, wid);
    check("wrap_bresp", wresp, 2'b00);
    axi_read(32'h8000_0000, 4'd0, 8'd3, 2'b01, 0);
    exp_q = '{64'hCAFE_0000_0000_00B1, 64'hCAFE_0001_0000_00B2,
              64'hCAFE_0002_0000_00B3, 64'hCAFE_0003_0000_00B0};
    check_read_q("wrap_words");
    axi_read(32'h8000_0018, 4'd0, 8'd3, 2'b10, 0);
    exp_q = '{64'hCAFE_0003_0000_00B0, 64'hCAFE_0000_0000_00B1,
              64'hCAFE_0001_0000_00B2, 64'hCAFE_0002_0000_00B3};
    check_read_q("wrap_read_order");
    check("wrap_read_last", rd_last[3], 1);

    // Arbitration: contested grant after reset goes to read, the next contested one to write
    reset = 1;
    tick();
    reset = 0;
    ar_addr = 32'h8000_0010; ar_id = 4'd1; ar_len = 0; ar_size = 3; ar_burst = 2'b01; ar_valid = 1;
    aw_addr = 32'h8000_0200; aw_id = 4'd2; aw_len = 0; aw_size = 3; aw_burst = 2'b01; aw_valid = 1;
    tick();
    check("arb1_ar_ready", ar_ready, 1);
    check("arb1_aw_ready", aw_ready, 0);
    tick();
    ar_valid = 0;
    r_ready  = 1;
    check("arb1_r_data", r_data, 64'hCAFE_0002_0000_00B3);
    tick();
    r_ready = 0;
    ar_addr = 32'h8000_0200; ar_id = 4'd6; ar_valid = 1;
    tick();
    check("arb2_aw_ready", aw_ready, 1);
    check("arb2_ar_ready", ar_ready, 0);
    tick();
    aw_valid = 0;
    w_data = 64'h0123_4567_89AB_CDEF; w_strb = 8'hFF; w_last = 1; w_valid = 1;
    check("arb2_w_ready", w_ready, 1);
    tick();
    w_valid = 0; w_last = 0; b_ready = 1;
    check("arb2_b_valid", b_valid, 1);
    check("arb2_b_resp", b_resp, 2'b00);
    check("arb2_b_id", b_id, 4'd2);
    tick();
    b_ready = 0;
    tick();
    check("arb3_ar_ready", ar_ready, 1);
    tick();
    ar_valid = 0;
    r_ready  = 1;
    check("arb3_r_data", r_data, 64'h0123_4567_89AB_CDEF);
    check("arb3_r_id", r_id, 4'd6);
    tick();
    r_ready = 0;

    // Error responses
    axi_read(32'h7FFF_FFF8, 4'd1, 8'd0, 2'b01, 0);
    check("err_below_resp", rd_resp[0], 2'b10);
    check("err_below_data", rd_data[0], 64'h0);
    axi_read(32'h8000_8000, 4'd1, 8'd0, 2'b01, 0);
    check("err_above_resp", rd_resp[0], 2'b10);
    check("err_above_data", rd_data[0], 64'h0);
    wbuf[0] = 64'h5A5A_5A5A_A5A5_A5A5; sbuf[0] = 8'hFF;
    axi_write(32'h8000_7FF8, 4'd1, 8'd0, 3'd3, 2'b01, 1, wresp, wid);
    check("top_word_bresp", wresp, 2'b00);
    axi_read(32'h8000_7FF8, 4'd1, 8'd0, 2'b01, 0);
    check("top_word_resp", rd_resp[0], 2'b00);
    check("top_word_data", rd_data[0], 64'h5A5A_5A5A_A5A5_A5A5);
    wbuf[0] = 64'h1; wbuf[1] = 64'h2;
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    axi_write(32'h8000_0300, 4'd1, 8'd3, 3'd3, 2'b01, 2, wresp, wid);
    check("err_early_last", wresp, 2'b10);
    axi_write(32'h8000_0308, 4'd1, 8'd0, 3'd3, 2'b11, 1, wresp, wid);
    check("err_burst11_w", wresp, 2'b10);
    axi_read(32'h8000_0010, 4'd1, 8'd0, 2'b11, 0);
    check("err_burst11_r", rd_resp[0], 2'b10);
    axi_write(32'h8000_0310, 4'd1, 8'd0, 3'd3, 2'b01, 2, wresp, wid);
    check("err_extra_beat", wresp, 2'b10);
    axi_write(32'h7FFF_FFF0, 4'd1, 8'd0, 3'd3, 2'b01, 1, wresp, wid);
    check("err_wr_range", wresp, 2'b10);

    // Reset during beat 2 of an 8-beat read
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 64'h7700_0000_0000_0000 + 64'(i);
      sbuf[i] = 8'hFF;
    end
    axi_write(32'h8000_0400, 4'd4, 8'd7, 3'd3, 2'b01, 8, wresp, wid);
    check("rst8_bresp", wresp, 2'b00);
    ar_addr = 32'h8000_0400; ar_id = 4'd3; ar_len = 7; ar_size = 3; ar_burst = 2'b01; ar_valid = 1;
    tick();
    tick();
    ar_valid = 0;
    r_ready  = 1;
    tick();
    tick();
    check("rst8_beat2_data", r_data, 64'h7700_0000_0000_0002);
    check("rst8_beat2_valid", r_valid, 1);
    reset = 1;
    #1;
    check("rst8_r_valid", r_valid, 0);
    check("rst8_r_last", r_last, 0);
    check("rst8_state", dbg_state, 0);
    r_ready = 0;
    tick();
    reset = 0;
    axi_read(32'h8000_0400, 4'd3, 8'd7, 2'b01, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'h7700_0000_0000_0000 + 64'(i));
    check_read_q("rst8_reread");
    check("rst8_reread_last", rd_last[7], 1);
    axi_read(32'h8000_0010, 4'd0, 8'd0, 2'b01, 0);
    check("rst8_word2_kept", rd_data[0], 64'hCAFE_0002_0000_00B3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_axi_mem_slave.md
# ysyx_22040759_axi_mem_slave

AXI4 responder (slave) backed by an on-chip 64-bit-wide memory array, answering the memory-side AXI port that the SimTop CPU/bridge drives as initiator. It is the simulation and FPGA-bring-up target for the CPU's instruction and data traffic when no external memory model is available. It handles one transaction at a time with round-robin read/write arbitration and supports FIXED, INCR and WRAP bursts with byte-strobed writes.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 64, data bus width; fixed at 64
- ID_WIDTH, 4, AXI ID width
- USER_WIDTH, 1, AXI user width
- MEM_WORDS, 4096, depth of the array in 64-bit words; power of two
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- clock  in  1  single clock; all state on the rising edge
- reset  in  1  asynchronous, active-high
- aw_valid / aw_ready  in / out  1 / 1  write address handshake
- aw_addr, aw_id, aw_len, aw_size, aw_burst  in  ADDR_WIDTH, ID_WIDTH, 8, 3, 2  write address fields
- w_valid / w_ready  in / out  1 / 1  write data handshake
- w_data, w_strb, w_last  in  64, 8, 1  write beat
- b_valid / b_ready  out / in  1 / 1  write response handshake
- b_resp, b_id, b_user  out  2, ID_WIDTH, USER_WIDTH  write response
- ar_valid / ar_ready  in / out  1 / 1  read address handshake
- ar_addr, ar_id, ar_len, ar_size, ar_burst  in  ADDR_WIDTH, ID_WIDTH, 8, 3, 2  read address fields
- r_valid / r_ready  out / in  1 / 1  read data handshake
- r_data, r_resp, r_last, r_id, r_user  out  64, 2, 1, ID_WIDTH, USER_WIDTH  read beat
- prot, lock, cache, qos and region are not ported; the top ties them off.

## Operation
- FSM states: IDLE, AR_ACK, RD, AW_ACK, WR, WRESP.
- IDLE: all readies and valids are 0. If only ar_valid is set, go to AR_ACK. If only aw_valid is set, go to AW_ACK. If both are set, grant the direction not granted last; `last_grant` resets to "write", so the first contested grant goes to read.
- AR_ACK: ar_ready=1 for exactly one cycle. Latch id, addr, len, size and burst, clear the beat counter, then go to RD. ar_valid is held by the AXI rule, so the handshake completes in this cycle.
- RD: r_valid=1 with registered r_data/r_resp/r_last. On each r handshake, advance the beat address and counter.
  - r_last=1 when beat counter == len.
  - The handshake on the last beat returns the FSM to IDLE.
- AW_ACK: aw_ready=1 for one cycle. Latch the AW fields, then go to WR.
- WR: w_ready=1. On each w handshake, write the bytes whose w_strb bit is set to the word at the current beat address, then advance.
  - Beats beyond len are accepted and dropped, and force SLVERR.
  - A w_last beat goes to WRESP. If beat counter != len at that beat, the response is SLVERR.
- WRESP: b_valid=1 and b_id=latched id. On the b handshake, return to IDLE.
- Address sequencing: byte address step = 1<<size. size>3 → SLVERR, and the step is treated as 8.
  - FIXED (00): the address never changes.
  - INCR (01): add the step.
  - WRAP (10): the wrap window is (len+1)<<size bytes, aligned to that size; the address wraps to the window base when it reaches the end. len must be 1, 3, 7 or 15, otherwise SLVERR and INCR behaviour.
  - burst 11: SLVERR with INCR behaviour.
- Word index = (addr - BASE_ADDR) >> 3. Narrow reads return the full aligned word, and the initiator selects the lanes.
- Out of range (addr < BASE_ADDR or index ≥ MEM_WORDS), per beat: reads return r_data=0 and resp=SLVERR (2'b10); writes are dropped and force b_resp=SLVERR.
  - Any SLVERR beat in a write makes b_resp SLVERR; otherwise b_resp is OKAY (00).
- b_user and r_user are always 0.
- The memory array has no reset; its contents survive reset.

## Timing
- Reset values: every ready, valid and last is 0; b_resp, r_resp, r_data, b_id and r_id are 0; FSM is in IDLE; last_grant is write.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and the burst is abandoned. Beats already written stay in memory.
- Read latency: ar_valid sampled in IDLE at edge N → ar_ready high in cycle N+1 → first r_valid in cycle N+2. With r_ready held high, one beat per cycle, so a len=L burst occupies L+1 cycles.
- Write: aw_ready in cycle N+1; w_ready from N+2. The edge that captures w_last raises b_valid in the next cycle.
- The earliest new grant is the cycle after the final r or b handshake, since the FSM passes through IDLE. Back-to-back transactions therefore have a 1-cycle gap.
- Stalls: while r_ready=0, r_data/r_resp/r_last/r_id hold stable. While w_valid=0, nothing is written.
- w beats arriving before the AW handshake are not accepted (w_ready=0 outside WR).

## Test plan
- Single read: ar_addr=0x8000_0010, len=0, size=3, id=5 → one beat, r_data=mem[2], r_last=1, r_id=5, r_resp=00, r_valid two cycles after ar_valid.
- INCR write then read: write 4 beats at 0x8000_0100 with data 0x11..0x44 and strb 0xFF → b_resp=00. Then read len=3 → 0x11, 0x22, 0x33, 0x44 with r_last on beat 3. Toggle r_ready randomly; data must be stable while stalled.
- Strobe and WRAP: write len=3, size=3, WRAP at 0x8000_0018 with strb 0x0F. Only low bytes of words 3, 0, 1, 2 change, in that order, and the upper bytes are unchanged.
- Simultaneous ar_valid and aw_valid from reset: read is granted first, then write. Repeating both requests gives the write first.
- Errors, checked separately:
  - Read at 0x7FFF_FFF8 → r_resp=10, r_data=0.
  - Write with w_last on beat 1 for len=3 → b_resp=10.
  - burst=11 → SLVERR.
- Reset mid-burst: assert reset during beat 2 of an 8-beat read → r_valid=0 immediately. After release, a new read completes normally and memory contents are unchanged.
